// File: rtl/fifo_word_packer_pkg.sv
// Shared types and constants for the FIFO word packer: the FSM state
// encoding, the default packed word width and the idle timer width.
package fifo_word_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  localparam int MSBD_DEF = 3;
  localparam int NPACK_DEF = 4;
  localparam int WORDW = (MSBD_DEF + 1) * NPACK_DEF;

  localparam int TMR_W = 8;

endpackage

// File: rtl/fifo_word_packer_idle_timer.sv
// Idle timer for a partially filled word. It counts enabled cycles and
// asserts expire while the count equals TMO-1. clr takes priority over en.
module pack_idle_timer
  import fifo_word_packer_pkg::*;
#(
  parameter int TMO = 8
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TMR_W-1:0] timer;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values; the reset is synchronous, so it sits
  // inside the clocked block and is not in the sensitivity list.
  always_ff @(posedge clock) begin
    if (rst || clr) begin
      timer <= '0;
    end else if (en) begin
      timer <= timer + 1'b1;
    end
  end

  assign expire = (timer == TMR_W'(TMO - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Drains the ring-buffer FIFO and packs NPACK consecutive entries into one
// word, LSB slot first. Partial words are flushed after TMO idle cycles.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int MSBD  = MSBD_DEF,
  parameter int NPACK = NPACK_DEF,
  parameter int TMO   = 8
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [MSBD:0]               fifoData,
  input  logic                        fifoEmpty,
  input  logic                        fifoPushSeen,
  output logic                        fifoPop,
  output logic [(MSBD+1)*NPACK-1:0]   outData,
  output logic [2:0]                  outCount,
  output logic                        outValid,
  input  logic                        outReady
);

  localparam int EW = MSBD + 1;

  pack_state_e state_q, state_d;
  logic [2:0]  cnt;
  logic        acc;
  logic        last_slot;
  logic        expire;
  logic        flush;
  logic        tmr_clr;

  // A push in the same cycle wins inside the FIFO, so such a pop is lost.
  assign acc       = (state_q == FILL) && !rst && !fifoEmpty && !fifoPushSeen;
  assign last_slot = (cnt == 3'(NPACK - 1));
  assign flush     = (state_q == FILL) && !acc && expire && (cnt != 3'd0);

  // The timer only runs in FILL while a partial word is pending.
  assign tmr_clr = (state_q != FILL) || acc || (cnt == 3'd0);

  pack_idle_timer #(
    .TMO (TMO)
  ) u_idle_timer (
    .clock  (clock),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (!tmr_clr),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    fifoPop  = 1'b0;
    outValid = 1'b0;
    unique case (state_q)
      FILL: begin
        fifoPop = !fifoEmpty;
        if ((acc && last_slot) || flush) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        outValid = 1'b1;
        if (outReady) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (rst) begin
      fifoPop = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt      <= '0;
      outData  <= '0;
      outCount <= '0;
    end else if (state_q == HOLD) begin
      if (outReady) begin
        cnt      <= '0;
        outData  <= '0;
        outCount <= '0;
      end
    end else begin
      if (acc) begin
        outData[int'(cnt)*EW +: EW] <= fifoData;
        cnt                         <= cnt + 3'd1;
        if (last_slot) begin
          outCount <= 3'(NPACK);
        end
      end else if (flush) begin
        outCount <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a queue models the FIFO, each
// scenario task checks its own hand-computed words, counts and timing.
module tb_fifo_word_packer;
  import fifo_word_packer_pkg::*;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       fifoData = '0;
  logic             fifoEmpty = 1'b1;
  logic             fifoPushSeen = 1'b0;
  logic             fifoPop;
  logic [WORDW-1:0] outData;
  logic [2:0]       outCount;
  logic             outValid;
  logic             outReady = 1'b0;

  int tests = 0;
  int fails = 0;
  int pops = 0;

  logic [3:0] q[$];
  logic       push_pending = 1'b0;
  logic [3:0] push_val = '0;

  fifo_word_packer #(
    .MSBD  (3),
    .NPACK (4),
    .TMO   (8)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .fifoData     (fifoData),
    .fifoEmpty    (fifoEmpty),
    .fifoPushSeen (fifoPushSeen),
    .fifoPop      (fifoPop),
    .outData      (outData),
    .outCount     (outCount),
    .outValid     (outValid),
    .outReady     (outReady)
  );

  always #5 clock = ~clock;

  task automatic drive_fifo();
    fifoEmpty = (q.size() == 0);
    fifoData  = (q.size() == 0) ? 4'h0 : q[0];
    #1;
  endtask

  task automatic load(input logic [3:0] vals[$]);
    foreach (vals[i]) q.push_back(vals[i]);
    drive_fifo();
  endtask

  // One clock: FIFO model updates 1 time unit after the edge, then settles.
  task automatic step();
    logic do_pop;
    do_pop = fifoPop && !fifoEmpty && !fifoPushSeen;
    @(posedge clock);
    #1;
    if (push_pending) q.push_back(push_val);
    if (do_pop) begin
      void'(q.pop_front());
      pops++;
    end
    push_pending = 1'b0;
    fifoPushSeen = 1'b0;
    drive_fifo();
  endtask

  task automatic wait_word(input string name, output int steps);
    steps = 0;
    while (!outValid && steps < 40) begin
      step();
      steps++;
    end
    if (!outValid) begin
      tests++;
      fails++;
      $display("FAIL %s: no word within %0d cycles", name, steps);
    end
  endtask

  task automatic test_reset();
    int n;
    step();
    tests++;
    if ({outValid, outData, outCount, fifoPop} !== 24'h0) begin
      fails++;
      $display("FAIL reset_init: valid=%b data=%h count=%0d pop=%b, want all 0",
               outValid, outData, outCount, fifoPop);
    end
    rst = 1'b0;
    load('{4'h1, 4'h2, 4'h3, 4'hE});
    repeat (3) step();
    rst = 1'b1;
    #1;
    tests++;
    if (fifoPop !== 1'b0) begin
      fails++;
      $display("FAIL reset_pop: fifoPop=%b want 0 while rst with FIFO non-empty", fifoPop);
    end
    repeat (2) step();
    tests++;
    if ({outValid, outData, outCount, fifoPop} !== 24'h0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b data=%h count=%0d pop=%b, want all 0",
               outValid, outData, outCount, fifoPop);
    end
    rst = 1'b0;
    load('{4'h9, 4'hA, 4'hB});
    outReady = 1'b1;
    wait_word("reset_after", n);
    tests++;
    if (outData !== 16'hBA9E || outCount !== 3'd4) begin
      fails++;
      $display("FAIL reset_after: data=%h count=%0d want BA9E/4", outData, outCount);
    end
    step();
  endtask

  task automatic test_full_word();
    int n;
    int p0;
    p0 = pops;
    outReady = 1'b1;
    load('{4'h1, 4'h2, 4'h3, 4'h4});
    wait_word("full", n);
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL full_latency: %0d cycles want 4", n);
    end
    tests++;
    if (outData !== 16'h4321 || outCount !== 3'd4) begin
      fails++;
      $display("FAIL full_word: data=%h count=%0d want 4321/4", outData, outCount);
    end
    step();
    tests++;
    if (outValid !== 1'b0 || outData !== 16'h0) begin
      fails++;
      $display("FAIL full_one_cycle: valid=%b data=%h want 0/0000", outValid, outData);
    end
    tests++;
    if (pops - p0 !== 4) begin
      fails++;
      $display("FAIL full_pops: %0d accepted pops want 4", pops - p0);
    end
  endtask

  task automatic test_partial_flush();
    int n;
    int early;
    early = 0;
    outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outValid) early++;
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL idle_empty: outValid high %0d cycles with cnt=0, want 0", early);
    end
    load('{4'h5, 4'h6});
    wait_word("partial", n);
    tests++;
    if (n !== 10) begin
      fails++;
      $display("FAIL partial_latency: %0d cycles want 10 (2 pops + 8 idle)", n);
    end
    tests++;
    if (outData !== 16'h0065 || outCount !== 3'd2) begin
      fails++;
      $display("FAIL partial_word: data=%h count=%0d want 0065/2", outData, outCount);
    end
    step();
  endtask

  task automatic test_push_collision();
    int n;
    outReady = 1'b1;
    load('{4'h1, 4'h2, 4'h3});
    step();
    fifoPushSeen = 1'b1;
    push_pending = 1'b1;
    push_val = 4'h4;
    #1;
    tests++;
    if (fifoPop !== 1'b1) begin
      fails++;
      $display("FAIL collide_pop: fifoPop=%b want 1 on collision cycle", fifoPop);
    end
    step();
    tests++;
    if (fifoPop !== 1'b1 || fifoData !== 4'h2) begin
      fails++;
      $display("FAIL collide_retry: pop=%b head=%h want 1/2", fifoPop, fifoData);
    end
    wait_word("collide", n);
    tests++;
    if (outData !== 16'h4321 || outCount !== 3'd4) begin
      fails++;
      $display("FAIL collide_word: data=%h count=%0d want 4321/4", outData, outCount);
    end
    step();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    bad = 0;
    outReady = 1'b0;
    load('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8});
    wait_word("bp_first", n);
    for (int i = 0; i < 10; i++) begin
      step();
      if (fifoPop !== 1'b0 || outValid !== 1'b1 || outData !== 16'h4321 || outCount !== 3'd4)
        bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL bp_hold: %0d cycles not stable (last pop=%b data=%h), want 0",
               bad, fifoPop, outData);
    end
    outReady = 1'b1;
    #1;
    tests++;
    if (fifoPop !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept_pop: fifoPop=%b want 0 in acceptance cycle", fifoPop);
    end
    step();
    tests++;
    if (outValid !== 1'b0 || fifoPop !== 1'b1) begin
      fails++;
      $display("FAIL bp_bubble: valid=%b pop=%b want 0/1", outValid, fifoPop);
    end
    wait_word("bp_second", n);
    tests++;
    if (n !== 4 || outData !== 16'h8765) begin
      fails++;
      $display("FAIL bp_second: %0d cycles data=%h want 4/8765", n, outData);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w[3];
    int n;
    exp_w = '{16'h3210, 16'h7654, 16'hBA98};
    outReady = 1'b1;
    load('{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB});
    for (int w = 0; w < 3; w++) begin
      wait_word("stream", n);
      tests++;
      if (outData !== exp_w[w] || outCount !== 3'd4) begin
        fails++;
        $display("FAIL stream_word%0d: data=%h count=%0d want %h/4",
                 w, outData, outCount, exp_w[w]);
      end
      step();
    end
    tests++;
    if (q.size() !== 0) begin
      fails++;
      $display("FAIL stream_drain: %0d entries left want 0", q.size());
    end
  endtask

  initial begin
    drive_fifo();
    test_reset();
    test_full_word();
    test_partial_flush();
    test_push_collision();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
